prog_count_ctrl: RTL and testbench
==================================

PROG_COUNT_CTRL -- requirements
Module: prog_count_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with parameters and ports as listed below.
REQ-002 Parameter TICK_DIV, default 4: clock cycles per count increment; legal range 1..255.
REQ-003 Parameter MAX_LIMIT, default 99: hard ceiling on the programmed target.
REQ-004 CLK  input  1  rising-edge system clock.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 start  input  1  start/resume request, level from button, edge-detected internally.
REQ-007 pause  input  1  pause request, edge-detected internally.
REQ-008 clear  input  1  abort/clear request, edge-detected internally.
REQ-009 auto_reload  input  1  when 1, restart automatically after reaching target.
REQ-010 max_count  input  7  requested target value, unsigned.
REQ-011 count_out  output  7  current count, registered.
REQ-012 busy  output  1  high in RUN or PAUSE.
REQ-013 done  output  1  one-cycle pulse on reaching target.
REQ-014 state_out  output  3  current FSM state encoding.

Function
REQ-015 Each of start/pause/clear SHALL produce a one-cycle internal pulse on a 0->1 transition, registered; a held level SHALL produce exactly one pulse.
REQ-016 FSM states SHALL be IDLE=0, RUN=1, PAUSE=2, DONE=3; other codes SHALL decode to IDLE on the next cycle.
REQ-017 Pulse priority SHALL be clear > pause > start in every state.
REQ-018 IDLE + start pulse: latch target = min(max_count, MAX_LIMIT), clear count_out and prescaler, go to RUN; if latched target = 0, go directly to DONE with done pulsed.
REQ-019 RUN: prescaler increments each cycle; when it equals TICK_DIV-1 it wraps to 0 and count_out increments by 1.
REQ-020 RUN: the increment that makes count_out equal target SHALL move the FSM to DONE in the same clock edge; done SHALL be high for exactly the first cycle in DONE.
REQ-021 count_out SHALL never exceed target nor MAX_LIMIT; no 7-bit wrap-around SHALL occur.
REQ-022 RUN + pause pulse: go to PAUSE; count_out and prescaler frozen.
REQ-023 PAUSE + start pulse: return to RUN, resuming from the frozen prescaler value; target unchanged.
REQ-024 DONE: count_out holds target; if auto_reload=1, the next cycle SHALL clear count_out and prescaler and enter RUN with the same target.
REQ-025 DONE + start pulse (auto_reload=0): relatch target from max_count and restart as in REQ-018.
REQ-026 clear pulse in any state: go to IDLE, count_out=0, prescaler=0, done=0.
REQ-027 max_count changes outside a latch event SHALL have no effect.
REQ-028 busy SHALL equal (state==RUN or state==PAUSE), registered with the state.

Reset
REQ-029 RST_N low SHALL asynchronously force state=IDLE, count_out=0, prescaler=0, target=0, done=0, busy=0, and all edge-detect history registers=0.
REQ-030 Reset release mid-count SHALL resume only from IDLE; a button held through reset SHALL NOT generate a pulse.

Structure
REQ-031 State encodings and the MAX_LIMIT default SHALL reside in the shared include file prog_count_defs.
REQ-032 Edge detection SHALL be a sub-module prog_edge_det, instantiated three times.
REQ-033 Counter, prescaler and FSM SHALL reside in prog_count_ctrl; no other sub-modules.

Verification
REQ-034 TICK_DIV=2, max_count=5, start pulse -> RUN; count_out steps 0..5 every 2 cycles; done high one cycle with count_out=5; state DONE.
REQ-035 max_count=120 -> target latched as 99; count stops at 99, done pulses once, no wrap.
REQ-036 Pause at count_out=3, hold 10 cycles, then start -> count_out stays 3 during PAUSE; after resume, 4 arrives after the remaining prescaler cycles.
REQ-037 auto_reload=1, max_count=2 -> repeating sequence 0,1,2,0,1,2 with done pulsed at every 2.
REQ-038 start and clear both rising in RUN -> IDLE, count_out=0; max_count=0 start -> DONE immediately with done pulse.
REQ-039 RST_N low while count_out=7 -> outputs zero asynchronously before next CLK edge; start held across release -> remains IDLE.

Source files
------------

// File: rtl/prog_count_defs.sv
// Shared definitions for the programmable count controller: state encodings,
// default ceiling and field widths.
package prog_count_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  localparam int MAX_LIMIT_DEF = 99;
  localparam int CNT_W         = 7;
  localparam int PS_W          = 8;

  function automatic logic [CNT_W-1:0] clamp_target(input logic [CNT_W-1:0] req,
                                                    input logic [CNT_W-1:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/prog_edge_det.sv
// Registered rising-edge detector for a button level; one pulse per 0->1 edge.
module prog_edge_det (
  input  logic CLK,
  input  logic RST_N,
  input  logic level,
  output logic pulse
);

  logic hist;
  logic armed;

  // armed stays low for the first cycle after reset so a level held through
  // reset is absorbed into hist instead of looking like a fresh edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist  <= 1'b0;
      armed <= 1'b0;
      pulse <= 1'b0;
    end else begin
      hist  <= level;
      armed <= 1'b1;
      pulse <= armed & level & ~hist;
    end
  end

endmodule

// File: rtl/prog_count_ctrl.sv
// Programmable up-counter with prescaler, pause/resume, clear and auto-reload.
module prog_count_ctrl
  import prog_count_defs::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int MAX_LIMIT = MAX_LIMIT_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] max_count,
  output logic [CNT_W-1:0] count_out,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_out
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_LIMIT);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);

  state_t           state;
  logic [PS_W-1:0]  presc;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] lat_target;
  logic             start_p;
  logic             pause_p;
  logic             clear_p;

  prog_edge_det u_start (.CLK(CLK), .RST_N(RST_N), .level(start), .pulse(start_p));
  prog_edge_det u_pause (.CLK(CLK), .RST_N(RST_N), .level(pause), .pulse(pause_p));
  prog_edge_det u_clear (.CLK(CLK), .RST_N(RST_N), .level(clear), .pulse(clear_p));

  assign lat_target = clamp_target(max_count, LIMIT);
  assign state_out  = state;

  // busy is written alongside every state change so it stays a pure flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      count_out <= '0;
      presc     <= '0;
      target    <= '0;
    end else begin
      done <= 1'b0;
      if (clear_p) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        count_out <= '0;
        presc     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_p && !pause_p) begin
              target    <= lat_target;
              count_out <= '0;
              presc     <= '0;
              if (lat_target == '0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_RUN;
                busy  <= 1'b1;
              end
            end
          end

          ST_RUN: begin
            if (pause_p) begin
              state <= ST_PAUSE;
              busy  <= 1'b1;
            end else if (presc == PS_LAST) begin
              presc <= '0;
              if (count_out < target)
                count_out <= count_out + 1'b1;
              if (count_out + 1'b1 >= target) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end

          ST_PAUSE: begin
            if (start_p && !pause_p) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end

          ST_DONE: begin
            if (pause_p) begin
              state <= ST_DONE;
            end else if (start_p) begin
              target    <= lat_target;
              count_out <= '0;
              presc     <= '0;
              if (lat_target == '0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_RUN;
                busy  <= 1'b1;
              end
            end else if (auto_reload) begin
              count_out <= '0;
              presc     <= '0;
              // A zero target has nothing to count; re-complete immediately.
              if (target == '0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_RUN;
                busy  <= 1'b1;
              end
            end
          end

          default: begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            count_out <= '0;
            presc     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_count_ctrl.sv
// Self-checking bench for prog_count_ctrl: table-driven runs plus pause,
// clear-priority and reset corner sequences, all checked through a scoreboard.
module tb_prog_count_ctrl;

  localparam int D = 2;
  localparam int LIM = 99;
  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_PAUSE = 3'd2, S_DONE = 3'd3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       start = 1'b0, pause = 1'b0, clear = 1'b0, auto_reload = 1'b0;
  logic [6:0] max_count = '0;
  logic [6:0] count_out;
  logic       busy, done;
  logic [2:0] state_out;

  prog_count_ctrl #(.TICK_DIV(D), .MAX_LIMIT(LIM)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .pause(pause), .clear(clear),
    .auto_reload(auto_reload), .max_count(max_count), .count_out(count_out),
    .busy(busy), .done(done), .state_out(state_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [6:0] cnt;
    logic       dn;
    logic       bsy;
  } exp_t;

  typedef struct {
    int maxc;
    bit ar;
    int ncyc;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic push(input string name, input logic [2:0] st, input int cnt,
                      input logic dn, input logic bsy);
    exp_t e;
    e.name = name; e.st = st; e.cnt = 7'(cnt); e.dn = dn; e.bsy = bsy;
    sbq.push_back(e);
  endtask

  task automatic chk_now();
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sbq.pop_front();
      if (state_out !== e.st || count_out !== e.cnt || done !== e.dn || busy !== e.bsy) begin
        failures++;
        $display("FAIL %s t=%0t got st=%0d cnt=%0d done=%b busy=%b want st=%0d cnt=%0d done=%b busy=%b",
                 e.name, $time, state_out, count_out, done, busy, e.st, e.cnt, e.dn, e.bsy);
      end
    end
  endtask

  task automatic step_chk();
    @(posedge CLK);
    #1;
    chk_now();
  endtask

  // Timeline after start is driven: i=1 pulse registered (still IDLE),
  // i=2 enters RUN at count 0, then one increment every D cycles.
  task automatic push_run(input string name, input int t, input bit ar, input int n);
    int j;
    for (int i = 1; i <= n; i++) begin
      if (i == 1) begin
        push(name, S_IDLE, 0, 1'b0, 1'b0);
      end else begin
        j = i - 2;
        if (ar && t > 0) j = j % (D * t + 1);
        if (j < D * t)       push(name, S_RUN, j / D, 1'b0, 1'b1);
        else if (j == D * t) push(name, S_DONE, t, 1'b1, 1'b0);
        else                 push(name, S_DONE, t, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic go_idle();
    start = 1'b0; pause = 1'b0; auto_reload = 1'b0; clear = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    clear = 1'b0;
    push("go_idle", S_IDLE, 0, 1'b0, 1'b0);
    step_chk();
  endtask

  vec_t vecs[5];

  initial begin
    int t;
    vecs[0] = '{maxc: 5,   ar: 1'b0, ncyc: 16};
    vecs[1] = '{maxc: 0,   ar: 1'b0, ncyc: 5};
    vecs[2] = '{maxc: 2,   ar: 1'b1, ncyc: 20};
    vecs[3] = '{maxc: 1,   ar: 1'b0, ncyc: 7};
    vecs[4] = '{maxc: 120, ar: 1'b0, ncyc: 206};

    #2 RST_N = 1'b0;
    #1;
    push("reset_state", S_IDLE, 0, 1'b0, 1'b0);
    chk_now();
    @(posedge CLK); #1;
    RST_N = 1'b1;

    foreach (vecs[k]) begin
      go_idle();
      max_count   = 7'(vecs[k].maxc);
      auto_reload = vecs[k].ar;
      t = (vecs[k].maxc > LIM) ? LIM : vecs[k].maxc;
      push_run($sformatf("vec%0d_max%0d", k, vecs[k].maxc), t, vecs[k].ar, vecs[k].ncyc);
      start = 1'b1;
      step_chk();
      start = 1'b0;
      for (int i = 2; i <= vecs[k].ncyc; i++) begin
        step_chk();
        if (i == 2) max_count = 7'($urandom_range(0, 127));
      end
    end

    // Pause at count 3, hold pause high, resume with remaining prescaler.
    go_idle();
    max_count = 7'd10;
    push_run("pause_pre", 10, 1'b0, 8);
    start = 1'b1;
    step_chk();
    start = 1'b0;
    for (int i = 2; i <= 8; i++) step_chk();
    pause = 1'b1;
    push("pause_pulse", S_RUN, 3, 1'b0, 1'b1);   step_chk();
    for (int i = 0; i < 11; i++) begin
      push("pause_hold", S_PAUSE, 3, 1'b0, 1'b1); step_chk();
    end
    pause = 1'b0;
    start = 1'b1;
    push("resume_s1", S_PAUSE, 3, 1'b0, 1'b1); step_chk();
    push("resume_s2", S_RUN,   3, 1'b0, 1'b1); step_chk();
    push("resume_s3", S_RUN,   4, 1'b0, 1'b1); step_chk();
    push("resume_s4", S_RUN,   4, 1'b0, 1'b1); step_chk();
    push("resume_s5", S_RUN,   5, 1'b0, 1'b1); step_chk();
    start = 1'b0;
    push("resume_s6", S_RUN,   5, 1'b0, 1'b1); step_chk();

    // start and clear rising together: clear wins.
    start = 1'b1;
    clear = 1'b1;
    push("clr_start_c1", S_RUN,  6, 1'b0, 1'b1); step_chk();
    push("clr_start_c2", S_IDLE, 0, 1'b0, 1'b0); step_chk();
    push("clr_start_c3", S_IDLE, 0, 1'b0, 1'b0); step_chk();

    // Reset mid-count with start held through release.
    go_idle();
    max_count = 7'd20;
    push_run("rst_pre", 20, 1'b0, 16);
    start = 1'b1;
    for (int i = 1; i <= 16; i++) step_chk();
    RST_N = 1'b0;
    #2;
    push("rst_async", S_IDLE, 0, 1'b0, 1'b0);
    chk_now();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("rst_held_start", S_IDLE, 0, 1'b0, 1'b0); step_chk();
    end
    start = 1'b0;
    push("rst_rearm", S_IDLE, 0, 1'b0, 1'b0); step_chk();
    push_run("rst_restart", 20, 1'b0, 3);
    start = 1'b1;
    for (int i = 1; i <= 3; i++) step_chk();
    start = 1'b0;

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
